// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue: DEPTH-entry FIFO of {instr, pc} between fetch and decode,
// with valid/ready on both sides and a flush that discards all entries.
module ir_fetch_queue #(
   parameter int WIDTH = 32,
   parameter int PC_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_instr,
   input  logic [PC_W-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_instr,
   output logic [PC_W-1:0]            out_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [WIDTH-1:0] instr_q [DEPTH];
   logic [PC_W-1:0]  pc_q    [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;
   // Handshake readiness comes from registered occupancy only, so no pop-to-push path.
   assign in_ready  = cnt_q != CW'(DEPTH);
   assign out_valid = cnt_q != '0;
   assign out_instr = out_valid ? instr_q[rd_q] : '0;
   assign out_pc    = out_valid ? pc_q[rd_q] : '0;
   assign count     = cnt_q;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   always_comb begin
      wr_d  = flush ? '0 : push ? wr_q + AW'(1) : wr_q;
      rd_d  = flush ? '0 : pop ? rd_q + AW'(1) : rd_q;
      cnt_d = flush ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push) begin
            instr_q[wr_q] <= in_instr;
            pc_q[wr_q]    <= in_pc;
         end
      end
   end
endmodule
